diram_phy_responder: RTL and testbench
======================================

Name: diram_phy_responder

Overview:
- Memory-side endpoint of the manager's DFI link to its local DiRAM stack slice.
- Decodes the per-manager command, address, bank and data bus, keeps open-row state per bank, and stores write bursts in an internal array.
- Returns read bursts on phy__phy valid/data at a fixed latency.
- Used as the synthesizable DRAM-side model behind each manager instance in array-level simulation and emulation.

Parameters:
- DATA_W, 64, width of dfi__phy__data and phy__dfi__data.
- PHY_ADDR_W, 12, width of dfi__phy__addr.
- BANK_W, 2, width of dfi__phy__bank; number of banks is 2**BANK_W.
- ROW_BITS, 4, row index taken from addr[ROW_BITS-1:0] at ACT; must be ≤ PHY_ADDR_W.
- COL_BITS, 4, column index taken from addr[COL_BITS-1:0] at RD/WR; must be ≤ PHY_ADDR_W.
- BURST_LEN, 2, data beats per RD/WR, ≥1.
- READ_LATENCY, 4, cycles from RD sample to first returned beat, ≥2.
- T_RCD, 3, minimum cycles from ACT to RD/WR on the same bank.

Ports:
- clk, in, 1, single clock; all logic is rising-edge.
- reset_poweron, in, 1, synchronous active-high reset.
- dfi__phy__cs, in, 1, command strobe, active-high.
- dfi__phy__cmd1, in, 1, command bit 1.
- dfi__phy__cmd0, in, 1, command bit 0.
- dfi__phy__addr, in, PHY_ADDR_W, row at ACT, start column at RD/WR.
- dfi__phy__bank, in, BANK_W, target bank.
- dfi__phy__data, in, DATA_W, write beats.
- phy__dfi__valid, out, 1, read beat valid.
- phy__dfi__data, out, DATA_W, read beat.
- phy__sys__error, out, 3, sticky protocol-error flags.

Behaviour:
- Interface: one clock (clk); reset_poweron is synchronous and active-high.
- Reset outputs: phy__dfi__valid=0, phy__dfi__data=0, phy__sys__error=0.
- Reset state: all banks closed, read pipeline flushed, burst/slot counters 0. Memory contents are not reset.
- Reset mid-burst: in-flight read beats are dropped, with no valid after reset. Remaining write beats are discarded; beats already written stay.
- Command decode: a command is sampled only when cs=1. {cmd1,cmd0} = 00 NOP, 01 ACT, 10 RD, 11 WR. With cs=0, cmd/addr/bank are ignored.
- ACT: sets open[bank]=1 and row[bank]=addr[ROW_BITS-1:0], and loads the tRCD counter for that bank with T_RCD-1. ACT to an already-open bank replaces the row (no precharge in the encoding). ACT has no slot restriction.
- Slot rule: RD/WR occupies the data slot for BURST_LEN cycles (the issue cycle plus BURST_LEN-1). A RD/WR sampled while the slot is busy is ignored and sets error[2].
- Closed-bank rule: RD/WR to a closed bank is ignored, sets error[0], and produces no valid beats.
- tRCD rule: RD/WR to an open bank whose tRCD counter is non-zero sets error[1] but still executes.
- Priority: if a command is both slot-busy and to a closed bank, both error[2] and error[0] set and the command is ignored.
- Address of beat k (0..BURST_LEN-1): {bank, row[bank], (col+k) mod 2**COL_BITS}. The column wraps inside the row and never carries into the row.
- WR data: beat 0 is dfi__phy__data in the WR cycle; beat k is dfi__phy__data k cycles later, sampled regardless of cs. Each beat is written on its own cycle.
- RD data: beat k is read from the array in cycle T+k (T = RD sample cycle) and presented with valid=1 in cycle T+READ_LATENCY+k. This is done with a READ_LATENCY-deep valid/data shift pipeline.
- Back-to-back reads spaced exactly BURST_LEN apart give a gap-free valid stream.
- Valid/data timing: phy__dfi__data holds 0 when valid=0. There is no backpressure; the consumer must always accept.
- Read-after-write: because of the slot rule, a RD at or after write-issue+BURST_LEN sees all beats of that write.
- Error flags: phy__sys__error bits are sticky until reset. A flag that is already set does not block later legal commands.

Test Plan:
- Basic read/write: ACT bank1 row5; after 3 cycles, WR col2 with beats A0,A1; after 2 more cycles, RD col2 -> valid exactly cycles T+4 and T+5 with A0,A1, and error=000.
- Column wrap: ACT bank0 row0; WR col15 with beats B0,B1; RD col15 -> returns B0 then B1 (B1 read from col0 of the same row); row1 contents unchanged.
- Closed bank: after reset, RD bank2 -> no valid for 10 cycles and error=001. A following ACT/WR/RD on bank2 then succeeds.
- Back-to-back reads: RD at T and T+2 -> valid high for four consecutive cycles T+4..T+7. A RD at T+1 in place of T+2 -> ignored, and error[2]=1.
- tRCD violation: ACT then RD on the same bank 1 cycle later -> error[1]=1 and data still returned at latency 4. ACT then RD 3 cycles later -> no new error.
- Reset mid-operation: RD issued, reset_poweron asserted at T+2 for 1 cycle -> no valid ever appears, error=000, banks closed. A RD afterwards without ACT sets error[0].

Source files
------------

// File: rtl/diram_phy_responder.sv
// DiRAM PHY responder: memory-side endpoint of a manager's DFI link.
// Decodes ACT/RD/WR, tracks the open row and tRCD per bank, stores write bursts in an
// internal array, and returns read bursts at a fixed latency through a shift pipeline.
module diram_phy_responder #(
    parameter int unsigned DATA_W       = 64,
    parameter int unsigned PHY_ADDR_W   = 12,
    parameter int unsigned BANK_W       = 2,
    parameter int unsigned ROW_BITS     = 4,
    parameter int unsigned COL_BITS     = 4,
    parameter int unsigned BURST_LEN    = 2,
    parameter int unsigned READ_LATENCY = 4,
    parameter int unsigned T_RCD        = 3
) (
    input  logic                  clk,
    input  logic                  reset_poweron,
    input  logic                  dfi__phy__cs,
    input  logic                  dfi__phy__cmd1,
    input  logic                  dfi__phy__cmd0,
    input  logic [PHY_ADDR_W-1:0] dfi__phy__addr,
    input  logic [BANK_W-1:0]     dfi__phy__bank,
    input  logic [DATA_W-1:0]     dfi__phy__data,
    output logic                  phy__dfi__valid,
    output logic [DATA_W-1:0]     phy__dfi__data,
    output logic [2:0]            phy__sys__error
);

    localparam int unsigned NBANKS    = 1 << BANK_W;
    localparam int unsigned MEM_AW    = BANK_W + ROW_BITS + COL_BITS;
    localparam int unsigned MEM_DEPTH = 1 << MEM_AW;
    // Counts beats still to go after the issue beat: at most BURST_LEN-1.
    localparam int unsigned LEFT_W    = (BURST_LEN < 2) ? 1 : $clog2(BURST_LEN);
    // tRCD counter is loaded with T_RCD-1 at ACT.
    localparam int unsigned TRCD_W    = (T_RCD < 2) ? 1 : $clog2(T_RCD);
    localparam int unsigned TRCD_LOAD = (T_RCD > 0) ? T_RCD - 1 : 0;

    typedef enum logic {
        StIdle,
        StBurst
    } state_e;

    // Burst sequencer state.
    state_e              state_q, state_d;
    logic                bst_wr_q, bst_wr_d;
    logic [BANK_W-1:0]   bst_bank_q, bst_bank_d;
    logic [ROW_BITS-1:0] bst_row_q, bst_row_d;
    logic [COL_BITS-1:0] bst_col_q, bst_col_d;
    logic [LEFT_W-1:0]   bst_left_q, bst_left_d;

    // Per-bank open-row bookkeeping.
    logic [NBANKS-1:0]   open_q;
    logic [ROW_BITS-1:0] row_q  [NBANKS];
    logic [TRCD_W-1:0]   trcd_q [NBANKS];

    // Sticky protocol errors: [2] slot busy, [1] tRCD violation, [0] closed bank.
    logic [2:0]          err_q;

    // Storage array; contents survive reset.
    logic [DATA_W-1:0]   mem [MEM_DEPTH];

    // Read return pipeline.
    logic [READ_LATENCY-1:0] pv_q;
    logic [DATA_W-1:0]       pd_q [READ_LATENCY];

    // Decode and per-cycle beat selection.
    logic                is_act;
    logic                is_rw;
    logic                slot_busy;
    logic                bank_open;
    logic                trcd_hit;
    logic                rw_exec;
    logic [COL_BITS-1:0] cmd_col;
    logic [ROW_BITS-1:0] cmd_row;
    logic                beat_en;
    logic                beat_wr;
    logic [MEM_AW-1:0]   beat_addr;
    logic                mem_we;
    logic                rd_en;
    logic [DATA_W-1:0]   rd_data;

    // Upper address bits beyond the row/column fields carry no meaning here.
    logic unused_addr;
    assign unused_addr = ^dfi__phy__addr;

    // Command decode and error classification.
    always_comb begin
        is_act    = dfi__phy__cs && !dfi__phy__cmd1 && dfi__phy__cmd0;
        is_rw     = dfi__phy__cs && dfi__phy__cmd1;
        slot_busy = (state_q == StBurst);
        bank_open = open_q[dfi__phy__bank];
        trcd_hit  = (trcd_q[dfi__phy__bank] != '0);
        rw_exec   = is_rw && !slot_busy && bank_open;
        cmd_col   = dfi__phy__addr[COL_BITS-1:0];
        cmd_row   = dfi__phy__addr[ROW_BITS-1:0];
    end

    // Pick the beat served this cycle: the issue beat of a new command or the next burst beat.
    always_comb begin
        beat_en   = 1'b0;
        beat_wr   = 1'b0;
        beat_addr = '0;
        if (rw_exec) begin
            beat_en   = 1'b1;
            beat_wr   = dfi__phy__cmd0;
            beat_addr = {dfi__phy__bank, row_q[dfi__phy__bank], cmd_col};
        end else if (slot_busy) begin
            beat_en   = 1'b1;
            beat_wr   = bst_wr_q;
            beat_addr = {bst_bank_q, bst_row_q, bst_col_q};
        end
        // Nothing touches the array while reset is held, so a cut-off burst stops cleanly.
        mem_we  = beat_en && beat_wr && !reset_poweron;
        rd_en   = beat_en && !beat_wr && !reset_poweron;
        rd_data = rd_en ? mem[beat_addr] : '0;
    end

    // Burst sequencer next state: remembers where the rest of the burst goes.
    always_comb begin
        state_d    = state_q;
        bst_wr_d   = bst_wr_q;
        bst_bank_d = bst_bank_q;
        bst_row_d  = bst_row_q;
        bst_col_d  = bst_col_q;
        bst_left_d = bst_left_q;
        unique case (state_q)
            StIdle: begin
                if (rw_exec && (BURST_LEN > 1)) begin
                    state_d    = StBurst;
                    bst_wr_d   = dfi__phy__cmd0;
                    bst_bank_d = dfi__phy__bank;
                    bst_row_d  = row_q[dfi__phy__bank];
                    // Column wraps within the row; it never carries into the row field.
                    bst_col_d  = cmd_col + COL_BITS'(1);
                    bst_left_d = LEFT_W'(BURST_LEN - 1);
                end
            end
            StBurst: begin
                bst_col_d  = bst_col_q + COL_BITS'(1);
                bst_left_d = bst_left_q - LEFT_W'(1);
                if (bst_left_q == LEFT_W'(1)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Burst sequencer registers.
    always_ff @(posedge clk) begin
        if (reset_poweron) begin
            state_q    <= StIdle;
            bst_wr_q   <= 1'b0;
            bst_bank_q <= '0;
            bst_row_q  <= '0;
            bst_col_q  <= '0;
            bst_left_q <= '0;
        end else begin
            state_q    <= state_d;
            bst_wr_q   <= bst_wr_d;
            bst_bank_q <= bst_bank_d;
            bst_row_q  <= bst_row_d;
            bst_col_q  <= bst_col_d;
            bst_left_q <= bst_left_d;
        end
    end

    // Bank state: ACT opens/replaces the row and restarts tRCD; counters run down otherwise.
    always_ff @(posedge clk) begin
        if (reset_poweron) begin
            open_q <= '0;
            for (int b = 0; b < NBANKS; b++) begin
                row_q[b]  <= '0;
                trcd_q[b] <= '0;
            end
        end else begin
            for (int b = 0; b < NBANKS; b++) begin
                if (is_act && (dfi__phy__bank == BANK_W'(b))) begin
                    open_q[b] <= 1'b1;
                    row_q[b]  <= cmd_row;
                    trcd_q[b] <= TRCD_W'(TRCD_LOAD);
                end else if (trcd_q[b] != '0) begin
                    trcd_q[b] <= trcd_q[b] - TRCD_W'(1);
                end
            end
        end
    end

    // Sticky error flags; an ignored command never blocks later legal ones.
    always_ff @(posedge clk) begin
        if (reset_poweron) begin
            err_q <= '0;
        end else begin
            err_q <= err_q | {is_rw && slot_busy, rw_exec && trcd_hit, is_rw && !bank_open};
        end
    end

    // Array write port: one beat per cycle.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[beat_addr] <= dfi__phy__data;
        end
    end

    // Read return pipeline: a beat read in cycle t appears on the outputs in t+READ_LATENCY.
    always_ff @(posedge clk) begin
        if (reset_poweron) begin
            pv_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pd_q[i] <= '0;
            end
        end else begin
            pv_q    <= {pv_q[READ_LATENCY-2:0], rd_en};
            pd_q[0] <= rd_data;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pd_q[i] <= pd_q[i-1];
            end
        end
    end

    assign phy__dfi__valid = pv_q[READ_LATENCY-1];
    assign phy__dfi__data  = pd_q[READ_LATENCY-1];
    assign phy__sys__error = err_q;

endmodule

// File: tb/tb_diram_phy_responder.sv
// Self-checking bench for diram_phy_responder: read beats are checked against a scoreboard
// of (cycle, data) expectations pushed when each RD is driven.
module tb_diram_phy_responder;

    localparam int RL = 4;

    typedef struct {
        int          cyc;
        logic [63:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_poweron;
    logic        dfi__phy__cs;
    logic        dfi__phy__cmd1;
    logic        dfi__phy__cmd0;
    logic [11:0] dfi__phy__addr;
    logic [1:0]  dfi__phy__bank;
    logic [63:0] dfi__phy__data;
    logic        phy__dfi__valid;
    logic [63:0] phy__dfi__data;
    logic [2:0]  phy__sys__error;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [3:0]  mrow [4];
    logic [63:0] mdl [logic [9:0]];
    exp_t        sb [$];
    exp_t        e;

    diram_phy_responder dut (
        .clk             (clk),
        .reset_poweron   (reset_poweron),
        .dfi__phy__cs    (dfi__phy__cs),
        .dfi__phy__cmd1  (dfi__phy__cmd1),
        .dfi__phy__cmd0  (dfi__phy__cmd0),
        .dfi__phy__addr  (dfi__phy__addr),
        .dfi__phy__bank  (dfi__phy__bank),
        .dfi__phy__data  (dfi__phy__data),
        .phy__dfi__valid (phy__dfi__valid),
        .phy__dfi__data  (phy__dfi__data),
        .phy__sys__error (phy__sys__error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: every valid beat must match the scoreboard head in cycle and data.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            tests++;
            fails++;
            $display("FAIL missed_beat: no valid in cycle %0d, required data %h",
                     sb[0].cyc, sb[0].data);
            void'(sb.pop_front());
        end
        if (phy__dfi__valid === 1'b1) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_valid: cycle %0d data %h, required no valid",
                         cyc, phy__dfi__data);
            end else begin
                e = sb.pop_front();
                if (e.cyc != cyc || phy__dfi__data !== e.data) begin
                    fails++;
                    $display("FAIL read_beat: got cycle %0d data %h, required cycle %0d data %h",
                             cyc, phy__dfi__data, e.cyc, e.data);
                end
            end
        end else if (reset_poweron === 1'b0) begin
            tests++;
            if (phy__dfi__valid !== 1'b0 || phy__dfi__data !== 64'd0) begin
                fails++;
                $display("FAIL idle_data: valid %b data %h, required 0 / 0",
                         phy__dfi__valid, phy__dfi__data);
            end
        end
    end

    function automatic logic [9:0] maddr(input logic [1:0] b, input logic [3:0] r,
                                         input logic [3:0] c);
        return {b, r, c};
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            dfi__phy__cs   = 1'b0;
            dfi__phy__data = {$urandom, $urandom};
            @(negedge clk);
        end
    endtask

    task automatic act(input logic [1:0] b, input logic [3:0] r);
        dfi__phy__cs   = 1'b1;
        {dfi__phy__cmd1, dfi__phy__cmd0} = 2'b01;
        dfi__phy__bank = b;
        dfi__phy__addr = {8'hA5, r};
        mrow[b]        = r;
        @(negedge clk);
        dfi__phy__cs   = 1'b0;
    endtask

    task automatic wr(input logic [1:0] b, input logic [3:0] c, input logic [63:0] d0,
                      input logic [63:0] d1);
        logic [3:0] c1;
        c1 = c + 4'd1;
        dfi__phy__cs   = 1'b1;
        {dfi__phy__cmd1, dfi__phy__cmd0} = 2'b11;
        dfi__phy__bank = b;
        dfi__phy__addr = {8'h3C, c};
        dfi__phy__data = d0;
        mdl[maddr(b, mrow[b], c)]  = d0;
        mdl[maddr(b, mrow[b], c1)] = d1;
        @(negedge clk);
        dfi__phy__cs   = 1'b0;
        dfi__phy__data = d1;
        @(negedge clk);
    endtask

    // exec=1 queues the two beats the model expects; exec=0 expects the RD to yield nothing.
    task automatic rd(input logic [1:0] b, input logic [3:0] c, input bit exec);
        logic [3:0] c1;
        exp_t x;
        c1 = c + 4'd1;
        dfi__phy__cs   = 1'b1;
        {dfi__phy__cmd1, dfi__phy__cmd0} = 2'b10;
        dfi__phy__bank = b;
        dfi__phy__addr = {8'h5A, c};
        dfi__phy__data = {$urandom, $urandom};
        if (exec) begin
            x.cyc = cyc + RL;
            x.data = mdl[maddr(b, mrow[b], c)];
            sb.push_back(x);
            x.cyc = cyc + RL + 1;
            x.data = mdl[maddr(b, mrow[b], c1)];
            sb.push_back(x);
        end
        @(negedge clk);
        dfi__phy__cs   = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL %s_drain: %0d beats outstanding, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic do_reset();
        reset_poweron = 1'b1;
        dfi__phy__cs  = 1'b0;
        repeat (2) @(negedge clk);
        reset_poweron = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if (phy__dfi__valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_valid: got %b, required 0", phy__dfi__valid);
        end
        tests++;
        if (phy__dfi__data !== 64'd0) begin
            fails++;
            $display("FAIL reset_data: got %h, required 0", phy__dfi__data);
        end
        tests++;
        if (phy__sys__error !== 3'b000) begin
            fails++;
            $display("FAIL reset_error: got %b, required 000", phy__sys__error);
        end
    endtask

    task automatic test_basic();
        do_reset();
        act(2'd1, 4'd5);
        idle(2);
        wr(2'd1, 4'd2, 64'hA0A0_0000_1111_0000, 64'hA1A1_0000_2222_0001);
        rd(2'd1, 4'd2, 1'b1);
        drain("basic");
        tests++;
        if (phy__sys__error !== 3'b000) begin
            fails++;
            $display("FAIL basic_error: got %b, required 000", phy__sys__error);
        end
    endtask

    task automatic test_col_wrap();
        do_reset();
        act(2'd0, 4'd1);
        idle(2);
        wr(2'd0, 4'd0, 64'hC0C0_C0C0_0000_0000, 64'hC1C1_C1C1_0000_0001);
        act(2'd0, 4'd0);
        idle(2);
        wr(2'd0, 4'd15, 64'hB0B0_B0B0_0000_000F, 64'hB1B1_B1B1_0000_0010);
        rd(2'd0, 4'd15, 1'b1);
        drain("wrap");
        act(2'd0, 4'd1);
        idle(2);
        rd(2'd0, 4'd0, 1'b1);
        drain("wrap_row1");
        tests++;
        if (phy__sys__error !== 3'b000) begin
            fails++;
            $display("FAIL wrap_error: got %b, required 000", phy__sys__error);
        end
    endtask

    task automatic test_closed_bank();
        do_reset();
        rd(2'd2, 4'd0, 1'b0);
        idle(10);
        tests++;
        if (phy__sys__error !== 3'b001) begin
            fails++;
            $display("FAIL closed_error: got %b, required 001", phy__sys__error);
        end
        act(2'd2, 4'd3);
        idle(2);
        wr(2'd2, 4'd4, 64'hD0D0_0000_0000_0004, 64'hD1D1_0000_0000_0005);
        rd(2'd2, 4'd4, 1'b1);
        drain("closed_recover");
        tests++;
        if (phy__sys__error !== 3'b001) begin
            fails++;
            $display("FAIL closed_sticky: got %b, required 001", phy__sys__error);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        act(2'd3, 4'd7);
        idle(2);
        wr(2'd3, 4'd0, 64'hE0E0_0000_0000_0000, 64'hE1E1_0000_0000_0001);
        wr(2'd3, 4'd2, 64'hE2E2_0000_0000_0002, 64'hE3E3_0000_0000_0003);
        rd(2'd3, 4'd0, 1'b1);
        idle(1);
        rd(2'd3, 4'd2, 1'b1);
        drain("b2b");
        tests++;
        if (phy__sys__error !== 3'b000) begin
            fails++;
            $display("FAIL b2b_error: got %b, required 000", phy__sys__error);
        end
        rd(2'd3, 4'd0, 1'b1);
        rd(2'd3, 4'd2, 1'b0);
        drain("b2b_busy");
        tests++;
        if (phy__sys__error !== 3'b100) begin
            fails++;
            $display("FAIL slot_busy_error: got %b, required 100", phy__sys__error);
        end
    endtask

    task automatic test_trcd();
        do_reset();
        act(2'd0, 4'd9);
        idle(2);
        wr(2'd0, 4'd5, 64'hF0F0_0000_0000_0005, 64'hF1F1_0000_0000_0006);
        do_reset();
        act(2'd0, 4'd9);
        rd(2'd0, 4'd5, 1'b1);
        drain("trcd_early");
        tests++;
        if (phy__sys__error !== 3'b010) begin
            fails++;
            $display("FAIL trcd_error: got %b, required 010", phy__sys__error);
        end
        do_reset();
        act(2'd0, 4'd9);
        idle(2);
        rd(2'd0, 4'd5, 1'b1);
        drain("trcd_ok");
        tests++;
        if (phy__sys__error !== 3'b000) begin
            fails++;
            $display("FAIL trcd_ok_error: got %b, required 000", phy__sys__error);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        act(2'd1, 4'd5);
        idle(2);
        rd(2'd1, 4'd2, 1'b0);
        idle(1);
        reset_poweron = 1'b1;
        @(negedge clk);
        reset_poweron = 1'b0;
        idle(10);
        tests++;
        if (phy__sys__error !== 3'b000) begin
            fails++;
            $display("FAIL reset_mid_error: got %b, required 000", phy__sys__error);
        end
        rd(2'd1, 4'd2, 1'b0);
        idle(8);
        tests++;
        if (phy__sys__error !== 3'b001) begin
            fails++;
            $display("FAIL reset_mid_closed: got %b, required 001", phy__sys__error);
        end
    endtask

    initial begin
        reset_poweron  = 1'b1;
        dfi__phy__cs   = 1'b0;
        dfi__phy__cmd1 = 1'b0;
        dfi__phy__cmd0 = 1'b0;
        dfi__phy__addr = '0;
        dfi__phy__bank = '0;
        dfi__phy__data = '0;
        for (int b = 0; b < 4; b++) mrow[b] = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_col_wrap();
        test_closed_bank();
        test_back_to_back();
        test_trcd();
        test_reset_mid();
        idle(4);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
